// File: rtl/dem_switch_decoder.sv
// dem_switch_decoder
// Receiver-side decoder for one DEM switching-tree node. Rebuilds the node
// input (x1 + x2) and the switching sequence (x1 - x2), recovers the PN bit,
// and tracks the running imbalance of the switching sequence. A sticky fault
// is raised when the imbalance spreads beyond SPREAD_LIMIT.
// Output is a single registered stage with valid/ready backpressure.
// Optional build macro: DEM_SWITCH_DECODER_PN_CHECK_EN adds a PN reference
// input and a saturating PN mismatch counter.

module dem_switch_decoder #(
  parameter int WIDTH        = 8,
  parameter int ACC_WIDTH    = 12,
  parameter int SPREAD_LIMIT = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [WIDTH-1:0]     x_out1_i,
  input  logic signed [WIDTH-1:0]     x_out2_i,
  input  logic                        clear_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic signed [WIDTH:0]       x_rec_o,
  output logic signed [WIDTH:0]       s_o,
  output logic                        pn_rec_o,
  output logic signed [ACC_WIDTH-1:0] acc_o,
  output logic                        fault_o,
`ifdef DEM_SWITCH_DECODER_PN_CHECK_EN
  input  logic                        pn_ref_i,
  output logic [7:0]                  pn_mismatch_cnt_o,
`endif
  output logic [15:0]                 sample_cnt_o
);

  // Accumulator arithmetic is done one bit wider than the widest operand so
  // the saturation test can see the true sum.
  localparam int SUM_W = ((ACC_WIDTH > WIDTH + 1) ? ACC_WIDTH : WIDTH + 1) + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX_C =
    {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN_C =
    {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] LIMIT_POS_C = SUM_W'(SPREAD_LIMIT);
  localparam logic signed [SUM_W-1:0] LIMIT_NEG_C = -LIMIT_POS_C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic                        valid_r;
  logic signed [WIDTH:0]       x_rec_r;
  logic signed [WIDTH:0]       s_r;
  logic                        pn_rec_r;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic                        fault_r;
  logic [15:0]                 sample_cnt_r;

  logic                        accept_s;
  logic signed [WIDTH:0]       x1_ext_s;
  logic signed [WIDTH:0]       x2_ext_s;
  logic signed [WIDTH:0]       x_rec_s;
  logic signed [WIDTH:0]       s_s;
  logic                        s_nonzero_s;
  logic                        pn_next_s;
  logic signed [SUM_W-1:0]     acc_sum_s;
  logic signed [SUM_W-1:0]     acc_sat_s;
  logic signed [ACC_WIDTH-1:0] acc_next_s;
  logic                        over_limit_s;

  assign ready_o  = !valid_r || ready_i;
  assign accept_s = valid_i && ready_o;

  assign valid_o      = valid_r;
  assign x_rec_o      = x_rec_r;
  assign s_o          = s_r;
  assign pn_rec_o     = pn_rec_r;
  assign acc_o        = acc_r;
  assign fault_o      = fault_r;
  assign sample_cnt_o = sample_cnt_r;

  // Full-precision reconstruction; one extra bit makes overflow impossible.
  always_comb begin
    x1_ext_s    = {x_out1_i[WIDTH-1], x_out1_i};
    x2_ext_s    = {x_out2_i[WIDTH-1], x_out2_i};
    x_rec_s     = x1_ext_s + x2_ext_s;
    s_s         = x1_ext_s - x2_ext_s;
    s_nonzero_s = (s_s != {(WIDTH+1){1'b0}});
    if (s_s[WIDTH]) begin
      pn_next_s = 1'b0;
    end else if (s_nonzero_s) begin
      pn_next_s = 1'b1;
    end else begin
      pn_next_s = pn_rec_r;
    end
  end

  // Saturating imbalance update and spread check on the post-update value.
  always_comb begin
    acc_sum_s = {{(SUM_W-ACC_WIDTH){acc_r[ACC_WIDTH-1]}}, acc_r}
              + {{(SUM_W-WIDTH-1){s_s[WIDTH]}}, s_s};
    if (acc_sum_s > ACC_MAX_C) begin
      acc_sat_s = ACC_MAX_C;
    end else if (acc_sum_s < ACC_MIN_C) begin
      acc_sat_s = ACC_MIN_C;
    end else begin
      acc_sat_s = acc_sum_s;
    end
    acc_next_s   = acc_sat_s[ACC_WIDTH-1:0];
    over_limit_s = (acc_sat_s > LIMIT_POS_C) || (acc_sat_s < LIMIT_NEG_C);
  end

  // Monitor FSM next state. A single large first sample can already exceed
  // the limit, so IDLE may go straight to FAULT rather than masking it.
  always_comb begin
    state_next_s = state_r;
    if (clear_i) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_next_s = over_limit_s ? ST_FAULT : ST_TRACK;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (accept_s && over_limit_s) begin
            state_next_s = ST_FAULT;
          end else begin
            state_next_s = ST_TRACK;
          end
        end
        ST_FAULT: state_next_s = ST_FAULT;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Output data stage: capture on accept, drop valid once drained.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_r  <= 1'b0;
      x_rec_r  <= '0;
      s_r      <= '0;
      pn_rec_r <= 1'b0;
    end else if (accept_s) begin
      valid_r  <= 1'b1;
      x_rec_r  <= x_rec_s;
      s_r      <= s_s;
      pn_rec_r <= pn_next_s;
    end else if (ready_i) begin
      valid_r  <= 1'b0;
    end
  end

  // Imbalance monitor state; clear takes priority over a coincident accept.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r      <= ST_IDLE;
      fault_r      <= 1'b0;
      acc_r        <= '0;
      sample_cnt_r <= 16'h0000;
    end else begin
      state_r <= state_next_s;
      fault_r <= (state_next_s == ST_FAULT);
      if (clear_i) begin
        acc_r        <= '0;
        sample_cnt_r <= 16'h0000;
      end else if (accept_s) begin
        acc_r <= acc_next_s;
        if (sample_cnt_r != 16'hFFFF) begin
          sample_cnt_r <= sample_cnt_r + 16'h0001;
        end
      end
    end
  end

`ifdef DEM_SWITCH_DECODER_PN_CHECK_EN
  logic [7:0] pn_mismatch_cnt_r;
  logic       pn_mismatch_s;

  assign pn_mismatch_cnt_o = pn_mismatch_cnt_r;

  // Zero-valued sequence samples carry no PN information and are skipped.
  always_comb begin
    if (accept_s && s_nonzero_s) begin
      pn_mismatch_s = (!s_s[WIDTH]) != pn_ref_i;
    end else begin
      pn_mismatch_s = 1'b0;
    end
  end

  // Saturating PN mismatch counter.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pn_mismatch_cnt_r <= 8'h00;
    end else if (clear_i) begin
      pn_mismatch_cnt_r <= 8'h00;
    end else if (pn_mismatch_s && (pn_mismatch_cnt_r != 8'hFF)) begin
      pn_mismatch_cnt_r <= pn_mismatch_cnt_r + 8'h01;
    end
  end
`endif

endmodule

// File: doc/dem_switch_decoder.md
Name: dem_switch_decoder

Overview:
- Receiver-side counterpart of the DEM switching block: takes the two split outputs of one switching node and reconstructs the node input and the switching sequence.
- Tracks accumulated switching-sequence imbalance (first-order mismatch shaping) and flags divergence.
- Sits in the DEM-DAC verification/monitor path, one instance per tree node; registered output with valid/ready backpressure.

Parameters:
- WIDTH, 8, width of each signed branch input (matches switching block data width)
- ACC_WIDTH, 12, width of signed imbalance accumulator
- SPREAD_LIMIT, 16, max allowed |accumulator| before fault

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- valid_i  in  1  input sample valid
- ready_o  out  1  decoder can accept sample
- x_out1_i  in  WIDTH  signed branch 1 from switching node
- x_out2_i  in  WIDTH  signed branch 2 from switching node
- clear_i  in  1  sync clear of fault, accumulator and counter
- valid_o  out  1  output sample valid
- ready_i  in  1  downstream accepts output
- x_rec_o  out  WIDTH+1  signed reconstructed input = x_out1_i + x_out2_i
- s_o  out  WIDTH+1  signed switching sequence = x_out1_i - x_out2_i
- pn_rec_o  out  1  recovered PN bit
- acc_o  out  ACC_WIDTH  signed running sum of s
- fault_o  out  1  sticky imbalance fault
- sample_cnt_o  out  16  accepted-sample count, saturating

Behaviour:
- Reset (reset_i=0, async): valid_o=0, x_rec_o=0, s_o=0, pn_rec_o=0, acc_o=0, fault_o=0, sample_cnt_o=0, FSM=IDLE.
- ready_o = !valid_o || ready_i (combinational). Accept = valid_i && ready_o.
- On accept: x_rec_o, s_o registered with full-precision sign-extended arithmetic (no overflow possible at WIDTH+1); valid_o=1 next cycle. Latency 1 cycle.
- Output held stable while valid_o && !ready_i; valid_o clears when ready_i=1 and no new accept in the same cycle.
- pn_rec_o: s>0 -> 1; s<0 -> 0; s==0 -> holds previous value.
- acc_o += s on each accept, saturating at ACC_WIDTH signed limits (no wrap).
- sample_cnt_o increments per accept, saturates at 16'hFFFF.
- FSM: IDLE -> TRACK on first accept. TRACK -> FAULT when post-update |acc| > SPREAD_LIMIT (fault_o=1 in the same cycle as the updated acc_o). FAULT is sticky; decoding continues in FAULT. Any state -> IDLE on clear_i.
- clear_i: zeroes acc_o, sample_cnt_o, fault_o next edge. If clear_i coincides with an accept, clear wins for acc/cnt/fault. The data path (x_rec_o, s_o, valid_o) still updates.
- Simultaneous accept and output-drain in the same cycle: new sample replaces the old one and valid_o stays 1.
- Reset asserted mid-stream: all state drops immediately; a pending output is discarded.

Optional Feature:
- Macro: DEM_SWITCH_DECODER_PN_CHECK_EN.
- Defined:
  - Adds input pn_ref_i (1) and output pn_mismatch_cnt_o (8, saturating, reset 0, cleared by clear_i).
  - On accept with s!=0, compares the recovered PN bit against pn_ref_i and increments the counter on mismatch.
  - s==0 samples are never counted.
- Undefined: neither port exists; no comparison logic.

Test Plan:
- Reset then accept x_out1=-1, x_out2=-2 -> next cycle valid_o=1, x_rec_o=-3, s_o=1, pn_rec_o=1, acc_o=1, sample_cnt_o=1, fault_o=0.
- Accept x_out1=-3, x_out2=-2 -> x_rec_o=-5, s_o=-1, pn_rec_o=0. Then accept 2,2 -> s_o=0, pn_rec_o stays 0.
- Hold ready_i=0 with valid_o=1 for 3 cycles while valid_i=1 -> ready_o=0, outputs unchanged. Release ready_i -> sample taken the same cycle, new output next cycle.
- Feed 17 samples of x_out1=1, x_out2=0 (s=+1) -> fault_o rises with acc_o=17. Then pulse clear_i -> acc_o=0, fault_o=0, sample_cnt_o=0.
- Assert reset_i=0 asynchronously mid-cycle with valid_o=1 -> all outputs 0 immediately, without waiting for a clock edge.
- With DEM_SWITCH_DECODER_PN_CHECK_EN: s=+1 with pn_ref_i=0 twice, and s=0 with pn_ref_i=1 once -> pn_mismatch_cnt_o=2.
